// File: rtl/gat_aggregator_pkg.sv
// Shared widths, FSM encoding and helpers for the GAT neighbourhood aggregator.
package gat_aggregator_pkg;
  localparam int MAX_NODES        = 16;
  localparam int NUM_NODE_WIDTH   = 5;
  localparam int ALPHA_DATA_WIDTH = 12;
  localparam int ALPHA_FRAC       = 8;
  localparam int DATA_WIDTH       = 8;
  localparam int NUM_FEATURES     = 16;
  localparam int AGG_ACC_WIDTH    = DATA_WIDTH + ALPHA_DATA_WIDTH + NUM_NODE_WIDTH + 1;
  localparam int IDX_WIDTH        = $clog2(MAX_NODES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} agg_state_t;

  function automatic logic [NUM_NODE_WIDTH-1:0] clamp_nodes(input logic [NUM_NODE_WIDTH-1:0] n);
    return (n > NUM_NODE_WIDTH'(MAX_NODES)) ? NUM_NODE_WIDTH'(MAX_NODES) : n;
  endfunction
endpackage

// File: rtl/gat_agg_mac_lane.sv
// One feature lane: alpha * feature accumulate, then floor-shift and saturate on load.
module gat_agg_mac_lane
  import gat_aggregator_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          acc_en,
  input  logic                          load,
  input  logic [ALPHA_DATA_WIDTH-1:0]   alpha,
  input  logic signed [DATA_WIDTH-1:0]  feat,
  output logic signed [DATA_WIDTH-1:0]  result
);
  localparam logic signed [AGG_ACC_WIDTH-1:0] SAT_MAX = AGG_ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [AGG_ACC_WIDTH-1:0] SAT_MIN = AGG_ACC_WIDTH'(-(1 << (DATA_WIDTH - 1)));

  logic signed [ALPHA_DATA_WIDTH:0]  alpha_s;
  logic signed [AGG_ACC_WIDTH-1:0]   prod;
  logic signed [AGG_ACC_WIDTH-1:0]   acc;
  logic signed [AGG_ACC_WIDTH-1:0]   acc_next;
  logic signed [AGG_ACC_WIDTH-1:0]   shifted;

  // The output sees acc_next so the final row lands in the same cycle it is loaded.
  always_comb begin
    alpha_s  = $signed({1'b0, alpha});
    prod     = AGG_ACC_WIDTH'(alpha_s) * AGG_ACC_WIDTH'(feat);
    acc_next = acc_en ? acc + prod : acc;
    shifted  = acc_next >>> ALPHA_FRAC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc <= clr ? '0 : acc_next;
      if (load) begin
        if (shifted > SAT_MAX)      result <= DATA_WIDTH'(SAT_MAX);
        else if (shifted < SAT_MIN) result <= DATA_WIDTH'(SAT_MIN);
        else                        result <= shifted[DATA_WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/gat_aggregator.sv
// GAT aggregation h'_i = sum_j alpha_ij * Wh_j, one neighbour row per cycle.
module gat_aggregator
  import gat_aggregator_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   sm_ready_i,
  input  logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0]  alpha_i,
  input  logic [NUM_NODE_WIDTH-1:0]              sm_num_of_nodes_i,
  output logic                                   feat_rd_en_o,
  output logic [NUM_NODE_WIDTH-1:0]              feat_rd_addr_o,
  input  logic [NUM_FEATURES*DATA_WIDTH-1:0]     feat_rd_data_i,
  output logic                                   agg_valid_o,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0]     agg_o,
  output logic                                   busy_o,
  output logic                                   overrun_o
);
  agg_state_t                            state;
  logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0] work_alpha, pend_alpha, new_alpha;
  logic [NUM_NODE_WIDTH-1:0]             work_n, pend_n, new_n;
  logic [IDX_WIDTH-1:0]                  rd_idx;
  logic                                  pend_valid, rd_valid;
  logic                                  start, from_pend, store, drop, drain;
  logic [ALPHA_DATA_WIDTH-1:0]           alpha_k;

  // softmax cannot be stalled, so every pulse is either started, parked in the slot or dropped
  always_comb begin
    start     = 1'b0;
    from_pend = 1'b0;
    case (state)
      IDLE:    start = sm_ready_i;
      DONE:    begin
        start     = pend_valid | sm_ready_i;
        from_pend = pend_valid;
      end
      default: start = 1'b0;
    endcase
    store     = sm_ready_i && (((state == RUN || state == DRAIN) && !pend_valid) ||
                               (state == DONE && pend_valid));
    drop      = sm_ready_i && (state == RUN || state == DRAIN) && pend_valid;
    new_alpha = from_pend ? pend_alpha : alpha_i;
    new_n     = clamp_nodes(from_pend ? pend_n : sm_num_of_nodes_i);
    alpha_k   = work_alpha[rd_idx*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH];
    drain     = (state == DRAIN);
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      work_alpha     <= '0;
      work_n         <= '0;
      pend_alpha     <= '0;
      pend_n         <= '0;
      pend_valid     <= 1'b0;
      rd_valid       <= 1'b0;
      rd_idx         <= '0;
      feat_rd_en_o   <= 1'b0;
      feat_rd_addr_o <= '0;
      agg_valid_o    <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      agg_valid_o <= 1'b0;
      rd_valid    <= feat_rd_en_o;
      rd_idx      <= feat_rd_addr_o[IDX_WIDTH-1:0];
      case (state)
        IDLE: ;
        RUN: begin
          if (feat_rd_addr_o == work_n - NUM_NODE_WIDTH'(1)) begin
            feat_rd_en_o <= 1'b0;
            state        <= DRAIN;
          end else begin
            feat_rd_addr_o <= feat_rd_addr_o + NUM_NODE_WIDTH'(1);
          end
        end
        DRAIN: begin
          agg_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // A new job overrides the IDLE/DONE transition above.
      if (start) begin
        work_alpha     <= new_alpha;
        work_n         <= new_n;
        feat_rd_addr_o <= '0;
        feat_rd_en_o   <= (new_n != '0);
        state          <= (new_n == '0) ? DRAIN : RUN;
      end
      if (store) begin
        pend_valid <= 1'b1;
        pend_alpha <= alpha_i;
        pend_n     <= sm_num_of_nodes_i;
      end else if (from_pend) begin
        pend_valid <= 1'b0;
      end
      if (drop) overrun_o <= 1'b1;
    end
  end

  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_lane
    gat_agg_mac_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (start),
      .acc_en (rd_valid),
      .load   (drain),
      .alpha  (alpha_k),
      .feat   (feat_rd_data_i[f*DATA_WIDTH +: DATA_WIDTH]),
      .result (agg_o[f*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_gat_aggregator.sv
// Directed and randomized checks of gat_aggregator against an arithmetic reference model.
module tb_gat_aggregator;
  import gat_aggregator_pkg::*;

  localparam int AV_W  = MAX_NODES * ALPHA_DATA_WIDTH;
  localparam int ROW_W = NUM_FEATURES * DATA_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                      sm_ready_i;
  logic [AV_W-1:0]           alpha_i;
  logic [NUM_NODE_WIDTH-1:0] sm_num_of_nodes_i;
  logic                      feat_rd_en_o;
  logic [NUM_NODE_WIDTH-1:0] feat_rd_addr_o;
  logic [ROW_W-1:0]          feat_rd_data_i = '0;
  logic                      agg_valid_o;
  logic [ROW_W-1:0]          agg_o;
  logic                      busy_o;
  logic                      overrun_o;

  gat_aggregator dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sm_ready_i        (sm_ready_i),
    .alpha_i           (alpha_i),
    .sm_num_of_nodes_i (sm_num_of_nodes_i),
    .feat_rd_en_o      (feat_rd_en_o),
    .feat_rd_addr_o    (feat_rd_addr_o),
    .feat_rd_data_i    (feat_rd_data_i),
    .agg_valid_o       (agg_valid_o),
    .agg_o             (agg_o),
    .busy_o            (busy_o),
    .overrun_o         (overrun_o)
  );

  // Wh buffer with one cycle of read latency
  logic signed [DATA_WIDTH-1:0] mem [MAX_NODES][NUM_FEATURES];
  always @(posedge clk) begin
    if (feat_rd_en_o)
      for (int f = 0; f < NUM_FEATURES; f++)
        feat_rd_data_i[f*DATA_WIDTH +: DATA_WIDTH] <= mem[feat_rd_addr_o[IDX_WIDTH-1:0]][f];
  end

  // scoreboard
  int               errors = 0;
  int               checks = 0;
  int               a_arr[MAX_NODES];
  logic [ROW_W-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [ROW_W-1:0] model(input int n);
    logic [ROW_W-1:0] r;
    int nc;
    longint s, q;
    nc = (n > MAX_NODES) ? MAX_NODES : n;
    r  = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      s = 0;
      for (int j = 0; j < nc; j++) s += longint'(a_arr[j]) * longint'(mem[j][f]);
      q = s / 256;
      if (s < 0 && q * 256 != s) q -= 1;
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      r[f*DATA_WIDTH +: DATA_WIDTH] = 8'(q);
    end
    return r;
  endfunction

  function automatic logic [AV_W-1:0] pack_alpha();
    logic [AV_W-1:0] v;
    for (int j = 0; j < MAX_NODES; j++) v[j*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH] = 12'(a_arr[j]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic set_alpha_all(input int v);
    for (int j = 0; j < MAX_NODES; j++) a_arr[j] = v;
  endtask

  task automatic set_alpha_rand();
    for (int j = 0; j < MAX_NODES; j++) a_arr[j] = int'($urandom_range(0, 4095));
  endtask

  task automatic set_mem_row(input int row, input int v);
    for (int f = 0; f < NUM_FEATURES; f++) mem[row][f] = 8'(v);
  endtask

  task automatic set_mem_rand();
    for (int j = 0; j < MAX_NODES; j++)
      for (int f = 0; f < NUM_FEATURES; f++) mem[j][f] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse(input int n, input bit push);
    sm_ready_i        = 1'b1;
    alpha_i           = pack_alpha();
    sm_num_of_nodes_i = 5'(n);
    if (push) exp_q.push_back(model(n));
  endtask

  // Pulse at the current negedge (cycle T); observe cycles T+1.. for reads and the result.
  task automatic run_single(input int n, input string tag, output logic [ROW_W-1:0] got);
    int nc, lat, reads;
    bit order_ok;
    nc = (n > MAX_NODES) ? MAX_NODES : n;
    pulse(n, 1'b1);
    lat = -1; reads = 0; order_ok = 1'b1; got = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) sm_ready_i = 1'b0;
      if (feat_rd_en_o) begin
        if (int'(feat_rd_addr_o) != reads || c != reads + 1) order_ok = 1'b0;
        reads++;
      end
      if (agg_valid_o) begin
        lat = c;
        got = agg_o;
        break;
      end
    end
    chk({tag, " latency"}, ROW_W'(lat), ROW_W'(nc + 2));
    chk({tag, " reads"}, ROW_W'(reads), ROW_W'(nc));
    chk({tag, " read order"}, ROW_W'(order_ok), ROW_W'(1));
    chk({tag, " agg"}, got, (exp_q.size() > 0) ? exp_q.pop_front() : '0);
    @(negedge clk);
    chk({tag, " idle busy"}, ROW_W'(busy_o), '0);
  endtask

  initial begin
    logic [ROW_W-1:0] got;
    int exp_cyc[3];
    int nvalid;

    rst_n = 1'b0; sm_ready_i = 1'b0; alpha_i = '0; sm_num_of_nodes_i = '0;
    set_alpha_all(0);
    set_mem_rand();
    repeat (3) @(negedge clk);
    chk("reset ctrl", ROW_W'({agg_valid_o, feat_rd_en_o, busy_o, overrun_o, feat_rd_addr_o}), '0);
    chk("reset agg", agg_o, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset ctrl", ROW_W'({agg_valid_o, feat_rd_en_o, busy_o, overrun_o}), '0);

    // N=2, alpha 0.5 each, rows 10 and -4 -> 3
    set_alpha_all(0); a_arr[0] = 128; a_arr[1] = 128;
    set_mem_row(0, 10); set_mem_row(1, -4);
    run_single(2, "n2", got);
    chk("n2 const", got, {NUM_FEATURES{8'h03}});

    // saturation both ways
    set_alpha_all(255);
    for (int j = 0; j < MAX_NODES; j++) set_mem_row(j, 127);
    run_single(16, "sat_pos", got);
    chk("sat_pos const", got, {NUM_FEATURES{8'h7f}});
    for (int j = 0; j < MAX_NODES; j++) set_mem_row(j, -128);
    run_single(16, "sat_neg", got);
    chk("sat_neg const", got, {NUM_FEATURES{8'h80}});

    // floor rounding
    set_alpha_all(0); a_arr[0] = 1;
    set_mem_row(0, -1);
    run_single(1, "floor_neg", got);
    chk("floor_neg const", got, {NUM_FEATURES{8'hff}});
    set_mem_row(0, 1);
    run_single(1, "floor_pos", got);
    chk("floor_pos const", got, '0);

    // empty neighbourhood and clamping
    set_alpha_rand(); set_mem_rand();
    run_single(0, "n0", got);
    chk("n0 const", got, '0);
    set_alpha_rand(); set_mem_rand();
    run_single(20, "clamp", got);

    // random jobs
    for (int i = 0; i < 16; i++) begin
      set_alpha_rand(); set_mem_rand();
      run_single(int'($urandom_range(0, MAX_NODES)), $sformatf("rand%0d", i), got);
    end

    // pulse in DONE while slot is full: slot drains, new pulse refills it
    set_mem_rand();
    exp_cyc = '{3, 6, 9};
    nvalid = 0;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      if (agg_valid_o) begin
        chk("refill cycle", ROW_W'(c), ROW_W'(nvalid < 3 ? exp_cyc[nvalid] : -1));
        chk("refill agg", agg_o, (exp_q.size() > 0) ? exp_q.pop_front() : '0);
        nvalid++;
      end
      if (c == 0 || c == 1 || c == 3) begin
        set_alpha_rand(); pulse(1, 1'b1);
      end else begin
        sm_ready_i = 1'b0;
      end
    end
    chk("refill count", ROW_W'(nvalid), ROW_W'(3));
    chk("refill no overrun", ROW_W'(overrun_o), '0);

    // pending path plus a dropped third pulse
    set_mem_rand();
    exp_cyc = '{5, 10, -1};
    nvalid = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) chk("overrun before", ROW_W'(overrun_o), '0);
      if (c == 4) chk("overrun set", ROW_W'(overrun_o), ROW_W'(1));
      if (agg_valid_o) begin
        chk("pend cycle", ROW_W'(c), ROW_W'(nvalid < 3 ? exp_cyc[nvalid] : -1));
        chk("pend agg", agg_o, (exp_q.size() > 0) ? exp_q.pop_front() : '0);
        nvalid++;
      end
      if (c == 0 || c == 2) begin
        set_alpha_rand(); pulse(3, 1'b1);
      end else if (c == 3) begin
        set_alpha_rand(); pulse(3, 1'b0);
      end else begin
        sm_ready_i = 1'b0;
      end
    end
    chk("pend count", ROW_W'(nvalid), ROW_W'(2));
    chk("overrun sticky", ROW_W'(overrun_o), ROW_W'(1));

    // reset in the middle of a job
    set_alpha_rand(); set_mem_rand();
    pulse(4, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      sm_ready_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort ctrl", ROW_W'({agg_valid_o, feat_rd_en_o, busy_o, overrun_o, feat_rd_addr_o}), '0);
    chk("abort agg", agg_o, '0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (agg_valid_o || feat_rd_en_o || busy_o) nvalid++;
    end
    chk("abort quiet", ROW_W'(nvalid), '0);
    chk("abort agg held", agg_o, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
